dmem_port_arbiter: RTL and testbench

//  Shares one single-port data memory (sync read, 1-cycle latency) between the core load/store port (C) and a debug/loader port (D).

---
 rtl/dmem_arb_pkg.sv | 9 +
 rtl/dmem_port_arbiter_if.sv | 16 +
 rtl/dmem_arb_starve.sv | 25 ++
 rtl/dmem_port_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: run-control states and read-return owner.
package dmem_arb_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} run_state_t;
  typedef enum logic {OWN_C, OWN_D} owner_t;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester port on the data memory: request fields, grant, and read return.
interface dmem_port_arbiter_if #(parameter int AW = 10) ();

  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_arb_starve.sv
// Saturating count of consecutive contended cycles the debug port has lost.
module dmem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != MAX)  cnt <= cnt + 4'd1;
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port sync-read data memory between the core (C) and debug (D) ports,
// with core priority, a starvation guard for D, and a halt/drain/halted run-control FSM.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_port_arbiter_if.slave  c,
  dmem_port_arbiter_if.slave  d,
  input  logic                halt_req,
  output logic                halt_ack,
  output logic                core_stall,
  output logic                m_en,
  output logic                m_we,
  output logic [3:0]          m_be,
  output logic [AW-1:0]       m_addr,
  output logic [31:0]         m_wdata,
  input  logic [31:0]         m_rdata
);

  run_state_t state_q, state_d;
  owner_t     rd_owner_q;
  logic       rd_pend_q;
  logic       c_win, d_win, rd_grant, starve_at_max;

  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (state_q == RUN && c.req && d.req && c_win),
    .clr    (d_win || !d.req),
    .at_max (starve_at_max)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (state_q == RUN) begin
      if (c.req && (!d.req || !starve_at_max)) c_win = 1'b1;
      else if (d.req)                          d_win = 1'b1;
    end else begin
      d_win = d.req;
    end
  end

  assign c.gnt    = c_win;
  assign d.gnt    = d_win;
  assign rd_grant = (c_win && !c.we) || (d_win && !d.we);

  // A read returning this cycle is already drained; only a new read grant keeps DRAIN busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_req)  state_d = DRAIN;
      DRAIN:   if (!rd_grant) state_d = HALTED;
      HALTED:  if (!halt_req) state_d = RUN;
      default:                state_d = RUN;
    endcase
  end

  // NOTE: only control flops live here and all take the async reset; the memory array is external.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_C;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_grant;
      rd_owner_q <= d_win ? OWN_D : OWN_C;
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_win) begin
      m_en = 1'b1; m_we = c.we; m_be = c.be; m_addr = c.addr; m_wdata = c.wdata;
    end else if (d_win) begin
      m_en = 1'b1; m_we = d.we; m_be = d.be; m_addr = d.addr; m_wdata = d.wdata;
    end
  end

  assign c.rvalid = rd_pend_q && (rd_owner_q == OWN_C);
  assign d.rvalid = rd_pend_q && (rd_owner_q == OWN_D);
  assign c.rdata  = c.rvalid ? m_rdata : 32'h0;
  assign d.rdata  = d.rvalid ? m_rdata : 32'h0;

  assign halt_ack = (state_q == HALTED);

  // With single-cycle read latency the post-grant wait ends in the c_rvalid cycle itself,
  // so it never adds a stall cycle beyond these two terms.
  assign core_stall = (state_q != RUN) || (c.req && !c_win);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: inline grant/state checks plus a read-return scoreboard.
module tb_dmem_port_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          halt_req, halt_ack, core_stall;
  logic          m_en, m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = 32'h0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] c_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] mem [0:(1<<AW)-1];

  dmem_port_arbiter_if #(.AW(AW)) c_if ();
  dmem_port_arbiter_if #(.AW(AW)) d_if ();

  dmem_port_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c          (c_if),
    .d          (d_if),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .core_stall (core_stall),
    .m_en       (m_en),
    .m_we       (m_we),
    .m_be       (m_be),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, sync read with one cycle of latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-return monitor: pops an expectation whenever a port presents rvalid.
  always @(negedge clk) begin
    if (c_if.rvalid) begin
      if (c_exp_q.size() == 0) check("c_rvalid_unexpected", 32'd1, 32'd0);
      else check("c_rdata", c_if.rdata, c_exp_q.pop_front());
    end else begin
      check("c_rdata_idle_zero", c_if.rdata, 32'h0);
    end
    if (d_if.rvalid) begin
      if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
      else check("d_rdata", d_if.rdata, d_exp_q.pop_front());
    end else begin
      check("d_rdata_idle_zero", d_if.rdata, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
    c_if.req = req; c_if.we = we; c_if.be = 4'hF; c_if.addr = addr; c_if.wdata = wdata;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
    d_if.req = req; d_if.we = we; d_if.be = 4'hF; d_if.addr = addr; d_if.wdata = wdata;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_c_gnt"},      {31'b0, c_if.gnt},    32'd0);
    check({tag, "_d_gnt"},      {31'b0, d_if.gnt},    32'd0);
    check({tag, "_c_rvalid"},   {31'b0, c_if.rvalid}, 32'd0);
    check({tag, "_d_rvalid"},   {31'b0, d_if.rvalid}, 32'd0);
    check({tag, "_halt_ack"},   {31'b0, halt_ack},    32'd0);
    check({tag, "_core_stall"}, {31'b0, core_stall},  32'd0);
    check({tag, "_m_en"},       {31'b0, m_en},        32'd0);
    check({tag, "_m_addr"},     32'(m_addr),          32'd0);
    check({tag, "_m_wdata"},    m_wdata,              32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h004] = 32'h11112222;
    mem[10'h008] = 32'h33334444;

    rst_n = 1'b0;
    halt_req = 1'b0;
    drive_c(1'b0, 1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0);
    step();
    @(negedge clk);
    check_idle_outputs("reset");
    step();
    rst_n = 1'b1;

    // 1: lone core read, zero-wait grant, data one cycle later.
    drive_c(1'b1, 1'b0, 10'h010, '0);
    @(negedge clk);
    check("t1_c_gnt",      {31'b0, c_if.gnt},   32'd1);
    check("t1_d_gnt",      {31'b0, d_if.gnt},   32'd0);
    check("t1_m_addr",     32'(m_addr),         32'h010);
    check("t1_m_en",       {31'b0, m_en},       32'd1);
    check("t1_core_stall", {31'b0, core_stall}, 32'd0);
    c_exp_q.push_back(32'hDEADBEEF);
    step();
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t1_c_rvalid",     {31'b0, c_if.rvalid}, 32'd1);
    check("t1_stall_rvalid", {31'b0, core_stall},  32'd0);

    // 2: sustained contention, D wins once every fifth cycle.
    step();
    drive_c(1'b1, 1'b1, 10'h100, 32'h0000_0C0C);
    drive_d(1'b1, 1'b1, 10'h104, 32'h0000_0D0D);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t2_c_gnt_%0d", i), {31'b0, c_if.gnt}, ((i % 5) == 4) ? 32'd0 : 32'd1);
      check($sformatf("t2_d_gnt_%0d", i), {31'b0, d_if.gnt}, ((i % 5) == 4) ? 32'd1 : 32'd0);
      step();
    end
    drive_c(1'b0, 1'b0, '0, '0);
    drive_d(1'b0, 1'b0, '0, '0);

    // 3: halt requested in the same cycle as a core read grant.
    step();
    drive_c(1'b1, 1'b0, 10'h004, '0);
    halt_req = 1'b1;
    @(negedge clk);
    check("t3_c_gnt",   {31'b0, c_if.gnt},   32'd1);
    check("t3_stall0",  {31'b0, core_stall}, 32'd0);
    check("t3_ack0",    {31'b0, halt_ack},   32'd0);
    c_exp_q.push_back(32'h11112222);
    step();
    drive_c(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t3_stall1",  {31'b0, core_stall},  32'd1);
    check("t3_ack1",    {31'b0, halt_ack},    32'd0);
    check("t3_rvalid1", {31'b0, c_if.rvalid}, 32'd1);
    step();
    @(negedge clk);
    check("t3_ack2",    {31'b0, halt_ack},   32'd1);
    check("t3_stall2",  {31'b0, core_stall}, 32'd1);

    // 4: halted, debug owns the memory; release restores core access.
    step();
    drive_c(1'b1, 1'b0, 10'h010, '0);
    drive_d(1'b1, 1'b1, 10'h020, 32'hA5A5A5A5);
    @(negedge clk);
    check("t4_d_gnt_wr", {31'b0, d_if.gnt}, 32'd1);
    check("t4_c_gnt_wr", {31'b0, c_if.gnt}, 32'd0);
    check("t4_m_we",     {31'b0, m_we},     32'd1);
    check("t4_m_be",     {28'b0, m_be},     32'hF);
    check("t4_m_addr",   32'(m_addr),       32'h020);
    check("t4_m_wdata",  m_wdata,           32'hA5A5A5A5);
    step();
    drive_d(1'b1, 1'b0, 10'h020, '0);
    @(negedge clk);
    check("t4_d_gnt_rd", {31'b0, d_if.gnt}, 32'd1);
    check("t4_c_gnt_rd", {31'b0, c_if.gnt}, 32'd0);
    d_exp_q.push_back(32'hA5A5A5A5);
    step();
    drive_d(1'b0, 1'b0, '0, '0);
    halt_req = 1'b0;
    @(negedge clk);
    check("t4_c_gnt_held", {31'b0, c_if.gnt}, 32'd0);
    check("t4_ack_held",   {31'b0, halt_ack}, 32'd1);
    step();
    @(negedge clk);
    check("t4_ack_rel",   {31'b0, halt_ack},   32'd0);
    check("t4_c_gnt_rel", {31'b0, c_if.gnt},   32'd1);
    check("t4_stall_rel", {31'b0, core_stall}, 32'd0);
    c_exp_q.push_back(32'hDEADBEEF);
    step();
    drive_c(1'b0, 1'b0, '0, '0);

    // 5: alternating C/D reads, fully pipelined returns.
    for (int i = 0; i < 4; i++) begin
      drive_c(1'b1, 1'b0, 10'h004, '0);
      drive_d(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check($sformatf("t5_c_gnt_%0d", i), {31'b0, c_if.gnt}, 32'd1);
      c_exp_q.push_back(32'h11112222);
      step();
      drive_c(1'b0, 1'b0, '0, '0);
      drive_d(1'b1, 1'b0, 10'h008, '0);
      @(negedge clk);
      check($sformatf("t5_d_gnt_%0d", i),  {31'b0, d_if.gnt},    32'd1);
      check($sformatf("t5_c_rv_%0d", i),   {31'b0, c_if.rvalid}, 32'd1);
      d_exp_q.push_back(32'h33334444);
      step();
    end
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_d_rv_last", {31'b0, d_if.rvalid}, 32'd1);

    // 6: reset lands while a debug read is in flight; its response is dropped.
    step();
    drive_d(1'b1, 1'b0, 10'h008, '0);
    @(negedge clk);
    check("t6_d_gnt", {31'b0, d_if.gnt}, 32'd1);
    step();
    rst_n = 1'b0;
    drive_d(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_idle_outputs("t6_rst");
    step();
    rst_n = 1'b1;
    drive_c(1'b1, 1'b1, 10'h200, 32'h12345678);
    @(negedge clk);
    check("t6_c_gnt_run", {31'b0, c_if.gnt},   32'd1);
    check("t6_stall_run", {31'b0, core_stall}, 32'd0);
    check("t6_ack_run",   {31'b0, halt_ack},   32'd0);
    step();
    drive_c(1'b0, 1'b0, '0, '0);
    step();
    step();

    check("c_queue_drained", 32'(c_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
